// File: rtl/axi_lite_xbar.sv
// 1-master / 3-slave AXI-lite decoding crossbar (s0 SRAM, s1 UART, s2 CLINT) with DECERR responder.
// One transaction in flight; requests are latched, responses pass straight through.
module axi_lite_xbar #(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_SIZE = 32'h0800_0000,
  parameter logic [31:0] S1_BASE = 32'ha000_03f8,
  parameter logic [31:0] S1_SIZE = 32'h0000_0008,
  parameter logic [31:0] S2_BASE = 32'ha000_0048,
  parameter logic [31:0] S2_SIZE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  input  logic [31:0] m_awaddr,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_wready,
  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,
  output logic [31:0] s0_araddr,
  output logic        s0_arvalid,
  input  logic        s0_arready,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  output logic [31:0] s0_awaddr,
  output logic        s0_awvalid,
  input  logic        s0_awready,
  output logic [31:0] s0_wdata,
  output logic [3:0]  s0_wstrb,
  output logic        s0_wvalid,
  input  logic        s0_wready,
  input  logic [1:0]  s0_bresp,
  input  logic        s0_bvalid,
  output logic        s0_bready,
  output logic [31:0] s1_araddr,
  output logic        s1_arvalid,
  input  logic        s1_arready,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp,
  input  logic        s1_rvalid,
  output logic        s1_rready,
  output logic [31:0] s1_awaddr,
  output logic        s1_awvalid,
  input  logic        s1_awready,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wvalid,
  input  logic        s1_wready,
  input  logic [1:0]  s1_bresp,
  input  logic        s1_bvalid,
  output logic        s1_bready,
  output logic [31:0] s2_araddr,
  output logic        s2_arvalid,
  input  logic        s2_arready,
  input  logic [31:0] s2_rdata,
  input  logic [1:0]  s2_rresp,
  input  logic        s2_rvalid,
  output logic        s2_rready,
  output logic [31:0] s2_awaddr,
  output logic        s2_awvalid,
  input  logic        s2_awready,
  output logic [31:0] s2_wdata,
  output logic [3:0]  s2_wstrb,
  output logic        s2_wvalid,
  input  logic        s2_wready,
  input  logic [1:0]  s2_bresp,
  input  logic        s2_bvalid,
  output logic        s2_bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B, ERR_R, ERR_B} state_t;
  localparam logic [1:0] SEL_ERR = 2'd3;
  localparam logic [1:0] DECERR  = 2'b11;

  state_t      state, next_state;
  logic [31:0] lat_addr, lat_data;
  logic [3:0]  lat_strb;
  logic [1:0]  sel;
  logic        aw_done, w_done;

  // 33-bit compare so a window ending at 4 GiB cannot wrap
  function automatic logic hit(input logic [31:0] addr, input logic [31:0] base,
                               input logic [31:0] size);
    logic [32:0] lo, hi;
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

  function automatic logic [1:0] decode(input logic [31:0] addr);
    if (hit(addr, S0_BASE, S0_SIZE))      return 2'd0;
    else if (hit(addr, S1_BASE, S1_SIZE)) return 2'd1;
    else if (hit(addr, S2_BASE, S2_SIZE)) return 2'd2;
    else                                  return SEL_ERR;
  endfunction

  logic        sel_arready, sel_rvalid, sel_awready, sel_wready, sel_bvalid;
  logic [31:0] sel_rdata;
  logic [1:0]  sel_rresp, sel_bresp;

  always_comb begin
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rdata   = '0;
    sel_rresp   = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = '0;
    case (sel)
      2'd0: begin
        sel_arready = s0_arready; sel_rvalid = s0_rvalid; sel_rdata = s0_rdata;
        sel_rresp = s0_rresp; sel_awready = s0_awready; sel_wready = s0_wready;
        sel_bvalid = s0_bvalid; sel_bresp = s0_bresp;
      end
      2'd1: begin
        sel_arready = s1_arready; sel_rvalid = s1_rvalid; sel_rdata = s1_rdata;
        sel_rresp = s1_rresp; sel_awready = s1_awready; sel_wready = s1_wready;
        sel_bvalid = s1_bvalid; sel_bresp = s1_bresp;
      end
      2'd2: begin
        sel_arready = s2_arready; sel_rvalid = s2_rvalid; sel_rdata = s2_rdata;
        sel_rresp = s2_rresp; sel_awready = s2_awready; sel_wready = s2_wready;
        sel_bvalid = s2_bvalid; sel_bresp = s2_bresp;
      end
      default: ;
    endcase
  end

  logic rd_accept, wr_accept, aw_hs, w_hs, wr_both;
  assign rd_accept = (state == IDLE) && m_arvalid;
  assign wr_accept = (state == IDLE) && m_awvalid && m_wvalid && !m_arvalid;
  assign aw_hs     = (state == WR_REQ) && !aw_done && sel_awready;
  assign w_hs      = (state == WR_REQ) && !w_done && sel_wready;
  assign wr_both   = (aw_done || aw_hs) && (w_done || w_hs);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m_arvalid)
          next_state = (decode(m_araddr) == SEL_ERR) ? ERR_R : RD_AR;
        else if (wr_accept)
          next_state = (decode(m_awaddr) == SEL_ERR) ? ERR_B : WR_REQ;
      end
      RD_AR:   if (sel_arready) next_state = RD_R;
      RD_R:    if (sel_rvalid && m_rready) next_state = IDLE;
      WR_REQ:  if (wr_both) next_state = WR_B;
      WR_B:    if (sel_bvalid && m_bready) next_state = IDLE;
      ERR_R:   if (m_rready) next_state = IDLE;
      ERR_B:   if (m_bready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_strb <= '0;
      sel      <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (rd_accept) begin
        lat_addr <= m_araddr;
        sel      <= decode(m_araddr);
      end else if (wr_accept) begin
        lat_addr <= m_awaddr;
        lat_data <= m_wdata;
        lat_strb <= m_wstrb;
        sel      <= decode(m_awaddr);
      end
      if (state == WR_REQ) begin
        if (wr_both) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end
    end
  end

  logic [2:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [31:0] s_araddr [3];
  logic [31:0] s_awaddr [3];
  logic [31:0] s_wdata  [3];
  logic [3:0]  s_wstrb  [3];

  // Everything handshake-related is held low while reset is asserted
  always_comb begin
    m_arready = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_bvalid  = 1'b0;
    m_bresp   = '0;
    s_arvalid = '0;
    s_rready  = '0;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    for (int i = 0; i < 3; i++) begin
      s_araddr[i] = '0;
      s_awaddr[i] = '0;
      s_wdata[i]  = '0;
      s_wstrb[i]  = '0;
    end
    if (rst_n) begin
      case (state)
        IDLE: begin
          m_arready = 1'b1;
          m_awready = wr_accept;
          m_wready  = wr_accept;
        end
        RD_R: begin
          m_rvalid = sel_rvalid;
          m_rdata  = sel_rdata;
          m_rresp  = sel_rresp;
        end
        WR_B: begin
          m_bvalid = sel_bvalid;
          m_bresp  = sel_bresp;
        end
        ERR_R: begin
          m_rvalid = 1'b1;
          m_rresp  = DECERR;
        end
        ERR_B: begin
          m_bvalid = 1'b1;
          m_bresp  = DECERR;
        end
        default: ;
      endcase
      for (int i = 0; i < 3; i++) begin
        if (sel == i[1:0]) begin
          case (state)
            RD_AR: begin
              s_arvalid[i] = 1'b1;
              s_araddr[i]  = lat_addr;
            end
            RD_R: s_rready[i] = m_rready;
            WR_REQ: begin
              s_awvalid[i] = !aw_done;
              s_wvalid[i]  = !w_done;
              s_awaddr[i]  = lat_addr;
              s_wdata[i]   = lat_data;
              s_wstrb[i]   = lat_strb;
            end
            WR_B: s_bready[i] = m_bready;
            default: ;
          endcase
        end
      end
    end
  end

  assign s0_arvalid = s_arvalid[0];
  assign s0_araddr  = s_araddr[0];
  assign s0_rready  = s_rready[0];
  assign s0_awvalid = s_awvalid[0];
  assign s0_awaddr  = s_awaddr[0];
  assign s0_wvalid  = s_wvalid[0];
  assign s0_wdata   = s_wdata[0];
  assign s0_wstrb   = s_wstrb[0];
  assign s0_bready  = s_bready[0];
  assign s1_arvalid = s_arvalid[1];
  assign s1_araddr  = s_araddr[1];
  assign s1_rready  = s_rready[1];
  assign s1_awvalid = s_awvalid[1];
  assign s1_awaddr  = s_awaddr[1];
  assign s1_wvalid  = s_wvalid[1];
  assign s1_wdata   = s_wdata[1];
  assign s1_wstrb   = s_wstrb[1];
  assign s1_bready  = s_bready[1];
  assign s2_arvalid = s_arvalid[2];
  assign s2_araddr  = s_araddr[2];
  assign s2_rready  = s_rready[2];
  assign s2_awvalid = s_awvalid[2];
  assign s2_awaddr  = s_awaddr[2];
  assign s2_wvalid  = s_wvalid[2];
  assign s2_wdata   = s_wdata[2];
  assign s2_wstrb   = s_wstrb[2];
  assign s2_bready  = s_bready[2];

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: routing, DECERR, arbitration, decode edges and mid-transaction reset.
module tb_axi_lite_xbar;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [3:0]  m_wstrb;
  wire         m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  wire  [31:0] m_rdata;
  wire  [1:0]  m_rresp, m_bresp;

  logic [2:0]  s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata [3];
  logic [1:0]  s_rresp [3];
  logic [1:0]  s_bresp [3];
  wire  [2:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  wire  [31:0] s_araddr [3];
  wire  [31:0] s_awaddr [3];
  wire  [31:0] s_wdata  [3];
  wire  [3:0]  s_wstrb  [3];

  int total = 0;
  int bad   = 0;

  axi_lite_xbar dut (
    .clk(clk), .rst_n(rst_n),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .s2_araddr(s_araddr[2]), .s2_arvalid(s_arvalid[2]), .s2_arready(s_arready[2]),
    .s2_rdata(s_rdata[2]), .s2_rresp(s_rresp[2]), .s2_rvalid(s_rvalid[2]), .s2_rready(s_rready[2]),
    .s2_awaddr(s_awaddr[2]), .s2_awvalid(s_awvalid[2]), .s2_awready(s_awready[2]),
    .s2_wdata(s_wdata[2]), .s2_wstrb(s_wstrb[2]), .s2_wvalid(s_wvalid[2]), .s2_wready(s_wready[2]),
    .s2_bresp(s_bresp[2]), .s2_bvalid(s_bvalid[2]), .s2_bready(s_bready[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_araddr = '0; m_arvalid = 0; m_rready = 0;
    m_awaddr = '0; m_awvalid = 0; m_wdata = '0; m_wstrb = '0; m_wvalid = 0; m_bready = 0;
    s_arready = '0; s_rvalid = '0; s_awready = '0; s_wready = '0; s_bvalid = '0;
    for (int i = 0; i < 3; i++) begin
      s_rdata[i] = '0; s_rresp[i] = '0; s_bresp[i] = '0;
    end
  endtask

  // Zero-wait read; esel 0..2 is the expected slave, 3 means DECERR
  task automatic rd_txn(input logic [31:0] addr, input int esel, input logic [31:0] data);
    m_araddr = addr; m_arvalid = 1;
    #2 chk("rd_arready", 32'(m_arready), 1);
    tick();
    m_arvalid = 0;
    #2;
    for (int i = 0; i < 3; i++) chk("rd_route", 32'(s_arvalid[i]), 32'(esel == i));
    if (esel < 3) begin
      chk("rd_araddr", s_araddr[esel], addr);
      s_arready[esel] = 1;
      s_rvalid[(esel + 1) % 3] = 1;
      #1 chk("rd_stray_rvalid", 32'(m_rvalid), 0);
      tick();
      s_arready = '0; s_rvalid = '0;
      s_rvalid[esel] = 1; s_rdata[esel] = data; s_rresp[esel] = 2'b00; m_rready = 1;
      #2 chk("rd_rvalid", 32'(m_rvalid), 1);
      chk("rd_rdata", m_rdata, data);
      chk("rd_rready", 32'(s_rready[esel]), 1);
      tick();
      s_rvalid = '0; m_rready = 0;
    end else begin
      chk("rd_err_rvalid", 32'(m_rvalid), 1);
      chk("rd_err_rresp", 32'(m_rresp), 3);
      m_rready = 1;
      tick();
      m_rready = 0;
    end
    #2 chk("rd_back_idle", 32'(m_arready), 1);
    chk("rd_rvalid_low", 32'(m_rvalid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    m_arvalid = 1; s_rvalid = 3'b111; s_bvalid = 3'b111;
    tick(); tick();
    chk("rst_arready", 32'(m_arready), 0);
    chk("rst_rvalid", 32'(m_rvalid), 0);
    chk("rst_bvalid", 32'(m_bvalid), 0);
    clear_inputs();
    rst_n = 1;
    tick();
    chk("idle_arready", 32'(m_arready), 1);
    chk("idle_awready", 32'(m_awready), 0);

    // SRAM read, slave responds one cycle after each valid
    m_araddr = 32'h8000_0010; m_arvalid = 1;
    tick();                                  // cycle 1
    m_arvalid = 0;
    #2 chk("t1_s0_arvalid_c1", 32'(s_arvalid[0]), 1);
    chk("t1_s0_araddr", s_araddr[0], 32'h8000_0010);
    chk("t1_others_idle", 32'(s_arvalid[2:1]), 0);
    chk("t1_arready_busy", 32'(m_arready), 0);
    tick();                                  // cycle 2
    s_arready[0] = 1;
    #2 chk("t1_s0_arvalid_c2", 32'(s_arvalid[0]), 1);
    chk("t1_no_r_yet", 32'(m_rvalid), 0);
    tick();                                  // cycle 3
    s_arready[0] = 0;
    s_rvalid[0] = 1; s_rdata[0] = 32'hdead_beef; s_rresp[0] = 2'b00; m_rready = 1;
    #2 chk("t1_arvalid_drop", 32'(s_arvalid[0]), 0);
    chk("t1_rdata", m_rdata, 32'hdead_beef);
    chk("t1_rresp", 32'(m_rresp), 0);
    chk("t1_rready", 32'(s_rready), 3'b001);
    tick();
    s_rvalid = '0; m_rready = 0;
    #2 chk("t1_done", 32'(m_rvalid), 0);

    // UART write, AW accepted early, W late
    m_awaddr = 32'ha000_03f8; m_wdata = 32'h41; m_wstrb = 4'b0001; m_awvalid = 1; m_wvalid = 1;
    #2 chk("t2_awready", 32'(m_awready), 1);
    chk("t2_wready", 32'(m_wready), 1);
    tick();                                  // cycle 1
    m_awvalid = 0; m_wvalid = 0; s_awready[1] = 1;
    #2 chk("t2_awvalid_c1", 32'(s_awvalid), 3'b010);
    chk("t2_wvalid_c1", 32'(s_wvalid), 3'b010);
    chk("t2_awaddr", s_awaddr[1], 32'ha000_03f8);
    chk("t2_wdata", s_wdata[1], 32'h41);
    chk("t2_wstrb", 32'(s_wstrb[1]), 1);
    tick();                                  // cycle 2
    s_awready[1] = 0;
    #2 chk("t2_awvalid_c2", 32'(s_awvalid[1]), 0);
    chk("t2_wvalid_c2", 32'(s_wvalid[1]), 1);
    tick();                                  // cycle 3
    s_wready[1] = 1;
    #2 chk("t2_wvalid_c3", 32'(s_wvalid[1]), 1);
    chk("t2_no_b_yet", 32'(m_bvalid), 0);
    tick();                                  // cycle 4
    s_wready[1] = 0; s_bvalid[1] = 1; s_bresp[1] = 2'b00; m_bready = 1;
    #2 chk("t2_wvalid_drop", 32'(s_wvalid[1]), 0);
    chk("t2_bvalid", 32'(m_bvalid), 1);
    chk("t2_bresp", 32'(m_bresp), 0);
    chk("t2_bready", 32'(s_bready), 3'b010);
    tick();
    s_bvalid = '0; m_bready = 0;
    #2 chk("t2_done", 32'(m_bvalid), 0);

    // Unmapped read, DECERR held until m_rready
    m_araddr = 32'h0000_1000; m_arvalid = 1;
    tick();                                  // cycle 1
    m_arvalid = 0;
    #2 chk("t3_rvalid_c1", 32'(m_rvalid), 1);
    chk("t3_rresp", 32'(m_rresp), 3);
    chk("t3_rdata", m_rdata, 0);
    chk("t3_no_slave", 32'(s_arvalid), 0);
    tick();                                  // cycle 2
    #2 chk("t3_rvalid_c2", 32'(m_rvalid), 1);
    tick();                                  // cycle 3
    m_rready = 1;
    #2 chk("t3_rvalid_c3", 32'(m_rvalid), 1);
    chk("t3_no_slave_c3", 32'(s_arvalid), 0);
    tick();
    m_rready = 0;
    #2 chk("t3_done", 32'(m_rvalid), 0);

    // Unmapped write, DECERR on B
    m_awaddr = 32'h0000_0010; m_wdata = 32'h7; m_wstrb = 4'hf; m_awvalid = 1; m_wvalid = 1;
    tick();
    m_awvalid = 0; m_wvalid = 0;
    #2 chk("te_bvalid", 32'(m_bvalid), 1);
    chk("te_bresp", 32'(m_bresp), 3);
    chk("te_no_slave", 32'(s_awvalid | s_wvalid), 0);
    m_bready = 1;
    tick();
    m_bready = 0;
    #2 chk("te_done", 32'(m_bvalid), 0);

    // Read and write presented together: read first
    m_araddr = 32'h8000_0000; m_arvalid = 1;
    m_awaddr = 32'ha000_0048; m_wdata = 32'h5; m_wstrb = 4'b1111; m_awvalid = 1; m_wvalid = 1;
    #2 chk("t4_arready", 32'(m_arready), 1);
    chk("t4_awready_c0", 32'(m_awready), 0);
    chk("t4_wready_c0", 32'(m_wready), 0);
    tick();
    m_arvalid = 0; s_arready[0] = 1;
    #2 chk("t4_s0_ar", 32'(s_arvalid), 3'b001);
    chk("t4_awready_c1", 32'(m_awready), 0);
    tick();
    s_arready[0] = 0; s_rvalid[0] = 1; s_rdata[0] = 32'h1234; m_rready = 1;
    #2 chk("t4_rdata", m_rdata, 32'h1234);
    chk("t4_awready_c2", 32'(m_awready), 0);
    tick();
    s_rvalid = '0; m_rready = 0;
    #2 chk("t4_awready_c3", 32'(m_awready), 1);
    chk("t4_wready_c3", 32'(m_wready), 1);
    tick();
    m_awvalid = 0; m_wvalid = 0; s_awready[2] = 1; s_wready[2] = 1;
    #2 chk("t4_s2_aw", 32'(s_awvalid), 3'b100);
    chk("t4_s2_w", 32'(s_wvalid), 3'b100);
    chk("t4_s2_awaddr", s_awaddr[2], 32'ha000_0048);
    tick();
    s_awready = '0; s_wready = '0; s_bvalid[2] = 1; s_bresp[2] = 2'b10; m_bready = 1;
    #2 chk("t4_bvalid", 32'(m_bvalid), 1);
    chk("t4_bresp", 32'(m_bresp), 2);
    tick();
    s_bvalid = '0; m_bready = 0;
    #2 chk("t4_done", 32'(m_bvalid), 0);

    // Decode boundaries
    rd_txn(32'ha000_03ff, 1, 32'h1111_0001);
    rd_txn(32'ha000_0400, 3, 32'h0);
    rd_txn(32'h87ff_fffc, 0, 32'h2222_0002);
    rd_txn(32'h8800_0000, 3, 32'h0);
    rd_txn(32'ha000_004f, 2, 32'h3333_0003);
    rd_txn(32'h7fff_fffc, 3, 32'h0);

    // Reset while waiting on a stalled slave
    m_araddr = 32'h8000_0100; m_arvalid = 1;
    tick();
    m_arvalid = 0;
    #2 chk("t6_s0_arvalid", 32'(s_arvalid[0]), 1);
    rst_n = 0;
    #1 chk("t6_forced_low", 32'(s_arvalid), 0);
    tick();
    rst_n = 1;
    #2 chk("t6_valids_low", 32'(s_arvalid), 0);
    chk("t6_idle", 32'(m_arready), 1);
    chk("t6_no_resp", 32'(m_rvalid), 0);
    rd_txn(32'h8000_0200, 0, 32'hcafe_f00d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
